// File: rtl/fs_accel_pkg.sv
// Shared constants and helpers for the sequential KxK window demux.
package fs_accel_pkg;
  localparam logic MODE_FILL  = 1'b0;
  localparam logic MODE_SLIDE = 1'b1;

  localparam int DEF_DW = 8;
  localparam int DEF_K  = 3;

  // Flat pixel index of window position (r,c); the pixel sits at [idx*DW +: DW].
  function automatic int pix_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction
endpackage

// File: rtl/fs_accel_win_ctrl.sv
// Window fill/emit control: fill counter, window counter, handshake decode and
// the row load/shift enables consumed by the row array in the top level.
module fs_accel_win_ctrl
  import fs_accel_pkg::*;
#(
  parameter  int K     = DEF_K,
  parameter  int CNT_W = 16,
  localparam int PW    = $clog2(K + 1),
  localparam int LW    = $clog2(K)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_mode,
  input  logic             i_in_valid,
  input  logic             i_win_ready,
  output logic             o_in_ready,
  output logic             o_win_valid,
  output logic [PW-1:0]    o_fill_cnt,
  output logic [CNT_W-1:0] o_win_count,
  output logic             o_load,
  output logic [LW-1:0]    o_load_idx,
  output logic             o_shift
);
  logic [PW-1:0]    r_fill;
  logic [CNT_W-1:0] r_win_cnt;
  logic [PW-1:0]    w_fill_nxt;
  logic             w_full, w_acc, w_cons, w_slide;

  assign w_full  = (r_fill == PW'(K));
  assign w_slide = (i_mode == MODE_SLIDE);

  // Ready stays high when the consumer drains this cycle, giving pass-through.
  assign o_in_ready  = !w_full || i_win_ready;
  assign o_win_valid = w_full;
  assign o_fill_cnt  = r_fill;
  assign o_win_count = r_win_cnt;

  assign w_acc  = i_in_valid && o_in_ready;
  assign w_cons = w_full && i_win_ready;

  always_comb begin
    o_load     = w_acc;
    o_shift    = w_cons && w_slide;
    o_load_idx = '0;
    if (!w_cons)
      o_load_idx = LW'(r_fill);
    else if (w_slide)
      o_load_idx = LW'(K - 1);
  end

  always_comb begin
    w_fill_nxt = r_fill;
    case ({w_acc, w_cons})
      2'b10:   w_fill_nxt = r_fill + PW'(1);
      2'b01:   w_fill_nxt = w_slide ? PW'(K - 1) : '0;
      2'b11:   w_fill_nxt = w_slide ? PW'(K) : PW'(1);
      default: w_fill_nxt = r_fill;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_fill    <= '0;
      r_win_cnt <= '0;
    end else begin
      r_fill <= w_fill_nxt;
      if (w_cons)
        r_win_cnt <= r_win_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/fs_accel_idemux_win.sv
// Steers one K-pixel row per accepted beat into a KxK window and hands full
// windows to the PE array; FILL emits independent windows, SLIDE reuses K-1 rows.
module fs_accel_idemux_win
  import fs_accel_pkg::*;
#(
  parameter  int DW    = DEF_DW,
  parameter  int K     = DEF_K,
  parameter  int CNT_W = 16,
  localparam int PW    = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K*DW-1:0]    in_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [K*K*DW-1:0]  win_data,
  output logic [PW-1:0]      fill_cnt,
  output logic [CNT_W-1:0]   win_count
);
  localparam int LW = $clog2(K);

  logic [K-1:0][K*DW-1:0] r_row;
  logic                   w_load, w_shift;
  logic [LW-1:0]          w_load_idx;

  fs_accel_win_ctrl #(.K(K), .CNT_W(CNT_W)) u_ctrl (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clear     (clear),
    .i_mode      (mode),
    .i_in_valid  (in_valid),
    .i_win_ready (win_ready),
    .o_in_ready  (in_ready),
    .o_win_valid (win_valid),
    .o_fill_cnt  (fill_cnt),
    .o_win_count (win_count),
    .o_load      (w_load),
    .o_load_idx  (w_load_idx),
    .o_shift     (w_shift)
  );

  // Shift first, then the load overrides its target slot (row K-1 on a slide+accept).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_row <= '0;
    end else begin
      if (w_shift)
        for (int r = 0; r < K - 1; r++)
          r_row[r] <= r_row[r+1];
      if (w_load)
        r_row[w_load_idx] <= in_data;
    end
  end

  assign win_data = win_valid ? r_row : '0;
endmodule
